behav_sram_1r1w_init: RTL
=========================

// Module: behav_sram_1r1w_init
// PURPOSE
//  Parametrised behavioural 1-read/1-write SRAM for simulation, successor to the per-macro *_ext models.
//  Adds configurable read latency, a defined read/write collision policy, a read-valid output and a
//  hardware init sweep after reset that writes INIT_VALUE to every word.
//  Instantiated in place of cache data/tag macros and scratchpads; no $random garbage on any output.
// PARAMETERS
//  DATA_W        64   word width in bits
//  DEPTH         512  number of words; need not be a power of two
//  MASK_GRAN     8    bits per write-mask lane; DATA_W % MASK_GRAN != 0 -> elaboration $error
//  READ_LATENCY  1    cycles from R0_en to R0_valid: 1 or 2; any other value -> elaboration $error
//  BYPASS        1    1: collision read returns newly written data; 0: returns old data
//  INIT_VALUE    0    DATA_W-bit value written to every word by the init sweep
//  (derived) ADDR_W = max(1,$clog2(DEPTH)); MASK_W = DATA_W/MASK_GRAN
// PORTS
//  clock      in   1       single clock, all state on rising edge
//  reset      in   1       synchronous, active-high
//  init_busy  out  1       1 while the init sweep runs; ports are ignored
//  W0_en      in   1       write enable
//  W0_addr    in   ADDR_W  write address
//  W0_data    in   DATA_W  write data
//  W0_mask    in   MASK_W  lane i writes bits [i*MASK_GRAN +: MASK_GRAN]
//  R0_en      in   1       read enable
//  R0_addr    in   ADDR_W  read address
//  R0_data    out  DATA_W  read data, qualified by R0_valid
//  R0_valid   out  1       one-cycle pulse per accepted read
// BEHAVIOUR
//  Reset (any cycle reset=1): FSM->INIT, sweep counter=0, init_busy=1, R0_valid=0, R0_data=0,
//   all read pipeline stages cleared. Reset mid-sweep or mid-read restarts the sweep from address 0.
//  FSM INIT: each cycle with reset=0 writes INIT_VALUE (all lanes) to word[counter], counter++.
//   Cycle writing word DEPTH-1 is the last INIT cycle; next cycle FSM=READY, init_busy=0.
//   Sweep takes exactly DEPTH cycles after reset deasserts. W0_en/R0_en ignored in INIT (no pulse).
//  FSM READY: stays until reset. Write and read accepted every cycle, independently.
//  Write: W0_en=1 and W0_addr<DEPTH -> masked lanes of word[W0_addr] updated at the edge;
//   W0_mask=0 is a legal no-op. W0_addr>=DEPTH -> write dropped, no other effect.
//  Read: R0_en=1 samples word at the edge of cycle T. READ_LATENCY=1: R0_data/R0_valid at T+1.
//   READ_LATENCY=2: data captured in stage 1 at T+1, presented at T+2; a write at T+1 to the
//   same address does not alter the in-flight data. R0_addr>=DEPTH -> R0_data=0, R0_valid still 1.
//  Collision (R0_en & W0_en & same in-range address, cycle T): BYPASS=1 -> returned word = W0_data on
//   masked lanes, old contents on unmasked lanes; BYPASS=0 -> old word. Memory always updated.
//  R0_data holds its last value when no read completes (no X, no random); R0_valid low those cycles.
//  Back-to-back reads every cycle sustain one result per cycle at both latencies.
// TESTING
//  1 Reset 1 cycle, DEPTH=512 -> init_busy high exactly 512 cycles; then read addr 0,511 -> 0, valid at T+1.
//  2 Write 0xDEADBEEF_CAFEF00D mask 0x0F to addr 5, read 5 -> 0x00000000_CAFEF00D after 1 cycle.
//  3 Collision addr 7 (old 0x11..11), write 0xFF..FF mask 0xF0: BYPASS=1 -> 0xFFFFFFFF_11111111;
//    BYPASS=0 -> 0x11111111_11111111; next read returns 0xFFFFFFFF_11111111 in both.
//  4 READ_LATENCY=2: read addr 3 at T, write addr 3 at T+1 -> R0_data at T+2 is old value, valid pulses once.
//  5 Assert reset at sweep cycle 100, release -> init_busy high another full 512 cycles; R0_en during INIT -> no valid.
//  6 DEPTH=300: write addr 310 dropped, read addr 310 -> valid=1, data=0; reads of addr 299 unaffected.

Source files
------------

// File: rtl/behav_sram_1r1w_init.sv
// Behavioural 1R1W SRAM with write mask, 1- or 2-cycle read latency, collision bypass and
// a hardware sweep that writes INIT_VALUE to every word after reset.
module behav_sram_1r1w_init #(
   parameter int                  DATA_W       = 64,
   parameter int                  DEPTH        = 512,
   parameter int                  MASK_GRAN    = 8,
   parameter int                  READ_LATENCY = 1,
   parameter bit                  BYPASS       = 1'b1,
   parameter logic [DATA_W-1:0]   INIT_VALUE   = '0,
   localparam int                 ADDR_W       = (DEPTH > 2) ? $clog2(DEPTH) : 1,
   localparam int                 MASK_W       = DATA_W / MASK_GRAN
) (
   input  logic              clock,
   input  logic              reset,
   output logic              init_busy,
   input  logic              W0_en,
   input  logic [ADDR_W-1:0] W0_addr,
   input  logic [DATA_W-1:0] W0_data,
   input  logic [MASK_W-1:0] W0_mask,
   input  logic              R0_en,
   input  logic [ADDR_W-1:0] R0_addr,
   output logic [DATA_W-1:0] R0_data,
   output logic              R0_valid
);

   // state  | meaning
   // S_INIT | sweep writes INIT_VALUE to word[sweep_cnt]; ports ignored
   // S_READY| normal operation, one read and one write per cycle

   if (DATA_W % MASK_GRAN != 0) begin : g_bad_mask
      $error("behav_sram_1r1w_init: DATA_W must be a multiple of MASK_GRAN");
   end
   if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_lat
      $error("behav_sram_1r1w_init: READ_LATENCY must be 1 or 2");
   end

   typedef enum logic {S_INIT, S_READY} state_t;

   localparam logic [ADDR_W:0]   DEPTH_EXT = DEPTH[ADDR_W:0];
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

   logic [DATA_W-1:0] mem [DEPTH];

   state_t            state;
   logic [ADDR_W-1:0] sweep_cnt;
   logic              s1_valid;
   logic [DATA_W-1:0] s1_data;

   logic              wr_ok;
   logic              rd_fire;
   logic              rd_in_range;
   logic [DATA_W-1:0] wr_merge;
   logic [DATA_W-1:0] rd_word;

   assign wr_ok       = (state == S_READY) && W0_en && ({1'b0, W0_addr} < DEPTH_EXT);
   assign rd_fire     = (state == S_READY) && R0_en;
   assign rd_in_range = ({1'b0, R0_addr} < DEPTH_EXT);

   // Merged word is both the memory update and the bypass value on a collision.
   always_comb begin
      wr_merge = '0;
      for (int i = 0; i < MASK_W; i++) begin
         wr_merge[i*MASK_GRAN +: MASK_GRAN] = W0_mask[i] ? W0_data[i*MASK_GRAN +: MASK_GRAN]
                                                         : mem[W0_addr][i*MASK_GRAN +: MASK_GRAN];
      end
   end

   always_comb begin
      rd_word = '0;
      if (rd_in_range) begin
         if (BYPASS && wr_ok && (W0_addr == R0_addr)) rd_word = wr_merge;
         else                                          rd_word = mem[R0_addr];
      end
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         if (state == S_INIT) mem[sweep_cnt] <= INIT_VALUE;
         else if (wr_ok)      mem[W0_addr]   <= wr_merge;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state     <= S_INIT;
         sweep_cnt <= '0;
         init_busy <= 1'b1;
         s1_valid  <= 1'b0;
         s1_data   <= '0;
         R0_valid  <= 1'b0;
         R0_data   <= '0;
      end else begin
         case (state)
            S_INIT: begin
               sweep_cnt <= sweep_cnt + 1'b1;
               if (sweep_cnt == LAST_ADDR) begin
                  state     <= S_READY;
                  init_busy <= 1'b0;
               end
            end
            S_READY: state <= S_READY;
            default: state <= S_INIT;
         endcase

         if (READ_LATENCY == 2) begin
            // Stage 1 holds the sampled word, so a later write cannot disturb it.
            s1_valid <= rd_fire;
            if (rd_fire) s1_data <= rd_word;
            R0_valid <= s1_valid;
            if (s1_valid) R0_data <= s1_data;
         end else begin
            R0_valid <= rd_fire;
            if (rd_fire) R0_data <= rd_word;
         end
      end
   end

endmodule
